// File: rtl/pc_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE sequencer owning the PC and a circular return-address stack.
// 3 cycles per instruction; input-wait and halt stall in EXECUTE-side states until in_valid / resume.
module pc_sequencer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_hlt,
  input  logic              instr_in,
  input  logic              instr_jr,
  input  logic              instr_jal,
  input  logic              instr_ret,
  input  logic              instr_jump,
  input  logic              instr_branch,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              in_valid,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              ir_load,
  output logic              exec_en,
  output logic              in_ack,
  output logic              halted,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic [15:0]       retired
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WAIT_IN, S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]   sp_q, sp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [15:0]        retired_q, retired_d;

  logic               commit;
  logic               ack;
  logic               retire;
  logic [ADDR_W-1:0]  pc_inc;
  logic [PTR_W-1:0]   sp_dec;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign sp_dec = sp_q - PTR_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ras_d     = ras_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    retired_d = retired_q;
    commit    = 1'b0;
    ack       = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (instr_hlt) begin
          state_d = S_HALT;
        end else if (instr_in) begin
          if (in_valid) begin
            commit = 1'b1;
            ack    = 1'b1;
            pc_d   = pc_inc;
          end else begin
            state_d = S_WAIT_IN;
          end
        end else begin
          commit = 1'b1;
          if (instr_jr) begin
            pc_d = reg_target;
          end else if (instr_jal) begin
            // Writing at sp when full lands on the oldest entry, giving circular overwrite.
            ras_d[sp_q] = pc_inc;
            sp_d        = sp_q + PTR_W'(1);
            if (cnt_q == RAS_FULL) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + CNT_W'(1);
            pc_d = jump_target;
          end else if (instr_ret) begin
            if (cnt_q == '0) begin
              unf_d = 1'b1;
              pc_d  = pc_inc;
            end else begin
              sp_d  = sp_dec;
              cnt_d = cnt_q - CNT_W'(1);
              pc_d  = ras_q[sp_dec];
            end
          end else if (instr_jump) begin
            pc_d = jump_target;
          end else if (instr_branch && branch_taken) begin
            pc_d = pc_inc + branch_offset;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          commit  = 1'b1;
          ack     = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (resume) begin
          retire  = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (commit || retire) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      sp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      retired_q <= retired_d;
      ras_q     <= ras_d;
    end
  end

  // Strobes are forced low while reset is asserted, whatever state the FSM was in.
  assign fetch_en      = !reset && (state_q == S_FETCH);
  assign ir_load       = !reset && (state_q == S_DECODE);
  assign exec_en       = !reset && commit;
  assign in_ack        = !reset && ack;
  assign halted        = !reset && (state_q == S_HALT);
  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: an instruction-level model predicts every cycle's outputs; one negedge process compares.
module tb_pc_sequencer;

  localparam int AW = 10;
  localparam int RD = 4;

  localparam int K_SEQ  = -1;
  localparam int K_BR   = 0;
  localparam int K_JUMP = 1;
  localparam int K_RET  = 2;
  localparam int K_JAL  = 3;
  localparam int K_JR   = 4;
  localparam int K_IN   = 5;
  localparam int K_HLT  = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          instr_hlt = 0, instr_in = 0, instr_jr = 0, instr_jal = 0;
  logic          instr_ret = 0, instr_jump = 0, instr_branch = 0, branch_taken = 0;
  logic [AW-1:0] jump_target = '0, reg_target = '0, branch_offset = '0;
  logic          in_valid = 0, resume = 0;
  logic [AW-1:0] pc;
  logic          fetch_en, ir_load, exec_en, in_ack, halted, ras_overflow, ras_underflow;
  logic [15:0]   retired;

  always #5 clock = ~clock;

  pc_sequencer #(.ADDR_W(AW), .RAS_DEPTH(RD), .RESET_PC(0)) dut (
    .clock(clock), .reset(reset),
    .instr_hlt(instr_hlt), .instr_in(instr_in), .instr_jr(instr_jr), .instr_jal(instr_jal),
    .instr_ret(instr_ret), .instr_jump(instr_jump), .instr_branch(instr_branch),
    .branch_taken(branch_taken), .jump_target(jump_target), .reg_target(reg_target),
    .branch_offset(branch_offset), .in_valid(in_valid), .resume(resume),
    .pc(pc), .fetch_en(fetch_en), .ir_load(ir_load), .exec_en(exec_en), .in_ack(in_ack),
    .halted(halted), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
    .retired(retired)
  );

  int total = 0;
  int fails = 0;

  // Expected outputs for the current cycle
  bit            chk_en = 0, e_full = 0;
  bit            e_fetch, e_ir, e_exec, e_ack, e_halt, e_ovf, e_unf;
  logic [AW-1:0] e_pc;
  logic [15:0]   e_ret;

  // Architectural model
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_ras [$];
  bit            m_ovf = 0, m_unf = 0;
  logic [15:0]   m_ret = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("fetch_en", 16'(fetch_en), 16'(e_fetch));
      chk("ir_load",  16'(ir_load),  16'(e_ir));
      chk("exec_en",  16'(exec_en),  16'(e_exec));
      chk("in_ack",   16'(in_ack),   16'(e_ack));
      chk("halted",   16'(halted),   16'(e_halt));
      if (e_full) begin
        chk("pc",            16'(pc),            16'(e_pc));
        chk("ras_overflow",  16'(ras_overflow),  16'(e_ovf));
        chk("ras_underflow", 16'(ras_underflow), 16'(e_unf));
        chk("retired",       retired,            e_ret);
      end
    end
  end

  // Start a cycle: clear inputs and publish the expectations for it.
  task automatic cyc(input bit f, input bit i, input bit x, input bit a, input bit h, input bit full);
    @(posedge clock);
    #1;
    reset = 0; instr_hlt = 0; instr_in = 0; instr_jr = 0; instr_jal = 0;
    instr_ret = 0; instr_jump = 0; instr_branch = 0; branch_taken = 0;
    in_valid = 0; resume = 0;
    e_fetch = f; e_ir = i; e_exec = x; e_ack = a; e_halt = h; e_full = full;
    e_pc = m_pc; e_ovf = m_ovf; e_unf = m_unf; e_ret = m_ret;
    chk_en = 1;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0); reset = 1;
    cyc(0, 0, 0, 0, 0, 0); reset = 1;
    m_pc = '0; m_ras.delete(); m_ovf = 0; m_unf = 0; m_ret = '0;
  endtask

  task automatic instr(input int kind, input logic [AW-1:0] tgt, input logic [AW-1:0] rt,
                       input logic [AW-1:0] off, input bit taken, input int hold,
                       input bit finish, input logic [6:0] extra);
    logic [6:0]    m;
    int            top;
    bit            stall;
    logic [AW-1:0] nxt;
    m = extra;
    if (kind >= 0) m[kind] = 1'b1;
    top = -1;
    for (int b = 0; b < 7; b++) if (m[b]) top = b;
    stall = (top == K_HLT) || (top == K_IN && hold > 0);

    cyc(1, 0, 0, 0, 0, 1); in_valid = 1; resume = 1;
    cyc(0, 1, 0, 0, 0, 1); in_valid = 1; resume = 1;
    cyc(0, 0, !stall, (top == K_IN) && !stall, 0, 1);
    {instr_hlt, instr_in, instr_jr, instr_jal, instr_ret, instr_jump, instr_branch} = m;
    jump_target = tgt; reg_target = rt; branch_offset = off; branch_taken = taken;
    in_valid = (top != K_IN) || (hold == 0);
    resume = 1;

    if (top == K_IN && hold > 0) begin
      for (int c = 1; c < hold; c++) begin
        cyc(0, 0, 0, 0, 0, 1); resume = 1;
      end
      if (!finish) return;
      cyc(0, 0, 1, 1, 0, 1); in_valid = 1;
    end
    if (top == K_HLT) begin
      for (int c = 0; c < hold; c++) begin
        cyc(0, 0, 0, 0, 1, 1); in_valid = 1;
      end
      if (!finish) return;
      cyc(0, 0, 0, 0, 1, 1); resume = 1;
    end

    nxt = m_pc + AW'(1);
    case (top)
      K_JR:   m_pc = rt;
      K_JAL: begin
        if (m_ras.size() == RD) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
        m_ras.push_back(nxt);
        m_pc = tgt;
      end
      K_RET: begin
        if (m_ras.size() == 0) begin
          m_unf = 1;
          m_pc  = nxt;
        end else begin
          m_pc = m_ras.pop_back();
        end
      end
      K_JUMP: m_pc = tgt;
      K_BR:   m_pc = taken ? nxt + off : nxt;
      default: m_pc = nxt;
    endcase
    m_ret = m_ret + 16'd1;
  endtask

  task automatic seqn(input int n);
    for (int k = 0; k < n; k++) instr(K_SEQ, '0, '0, '0, 0, 0, 1, '0);
  endtask

  initial begin
    do_reset();

    seqn(4);
    chk("pin_seq_pc", 16'(m_pc), 16'd4);
    chk("pin_seq_retired", m_ret, 16'd4);

    instr(K_JUMP, 10'h3F0, '0, '0, 0, 0, 1, '0);
    chk("pin_jump_pc", 16'(m_pc), 16'h3F0);
    seqn(15);
    chk("pin_top_pc", 16'(m_pc), 16'h3FF);
    seqn(1);
    chk("pin_wrap_pc", 16'(m_pc), 16'h000);

    seqn(5);
    instr(K_BR, '0, '0, 10'h3FC, 1, 0, 1, '0);
    chk("pin_branch_taken", 16'(m_pc), 16'd2);
    instr(K_BR, '0, '0, 10'h3FC, 0, 0, 1, '0);
    chk("pin_branch_not_taken", 16'(m_pc), 16'd3);
    instr(K_JR, 10'h155, 10'd10, '0, 1, 0, 1, 7'b0000011);
    chk("pin_jr_priority", 16'(m_pc), 16'd10);

    instr(K_JAL, 10'h100, '0, '0, 0, 0, 1, '0);
    instr(K_JAL, 10'h200, '0, '0, 0, 0, 1, '0);
    instr(K_RET, '0, '0, '0, 0, 0, 1, '0);
    chk("pin_ret1_pc", 16'(m_pc), 16'h101);
    instr(K_RET, '0, '0, '0, 0, 0, 1, '0);
    chk("pin_ret2_pc", 16'(m_pc), 16'd11);

    for (int j = 0; j < 5; j++) instr(K_JAL, AW'((j + 2) * 16), '0, '0, 0, 0, 1, '0);
    chk("pin_overflow", 16'(m_ovf), 16'd1);
    for (int j = 0; j < 4; j++) instr(K_RET, '0, '0, '0, 0, 0, 1, '0);
    chk("pin_ret_after_ovf", 16'(m_pc), 16'h021);
    instr(K_RET, '0, '0, '0, 0, 0, 1, '0);
    chk("pin_underflow", 16'(m_unf), 16'd1);
    chk("pin_underflow_pc", 16'(m_pc), 16'h022);

    instr(K_IN, '0, '0, '0, 0, 5, 1, '0);
    chk("pin_in_wait_pc", 16'(m_pc), 16'h023);
    instr(K_IN, '0, 10'h300, '0, 0, 0, 1, 7'b0010000);
    chk("pin_in_over_jr", 16'(m_pc), 16'h024);

    instr(K_JUMP, 10'd7, '0, '0, 0, 0, 1, '0);
    instr(K_HLT, '0, '0, '0, 0, 20, 1, '0);
    chk("pin_resume_pc", 16'(m_pc), 16'd8);
    chk("pin_resume_retired", m_ret, 16'd47);

    instr(K_IN, '0, '0, '0, 0, 3, 0, '0);
    do_reset();
    seqn(1);
    chk("pin_after_waitin_reset", 16'(m_pc), 16'd1);
    instr(K_HLT, '0, '0, '0, 0, 4, 0, '0);
    do_reset();
    for (int j = 0; j < 3; j++) instr(K_JAL, AW'(64 * (j + 1)), '0, '0, 0, 0, 1, '0);
    do_reset();
    instr(K_RET, '0, '0, '0, 0, 0, 1, '0);
    chk("pin_reset_ret_unf", 16'(m_unf), 16'd1);
    chk("pin_reset_ret_pc", 16'(m_pc), 16'd1);
    chk("pin_reset_no_ovf", 16'(m_ovf), 16'd0);

    cyc(1, 0, 0, 0, 0, 1);
    @(negedge clock);
    #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle control FSM that owns and sequences the processor's program counter. Steps each instruction through fetch, decode and execute. Selects the next PC from sequential, jump, register-jump, branch, call and return sources, and stalls on input-wait and halt. Sits between instruction memory / decoder and the datapath; its `pc` output drives the instruction-memory address.

## Interface
- `ADDR_W`, 10, PC / instruction-address width
- `RAS_DEPTH`, 4, return-address-stack entries (power of 2, ≥2)
- `RESET_PC`, 0, PC value loaded on reset
- `clock` in 1, single system clock; all state changes on rising edge
- `reset` in 1, synchronous, active-high
- `instr_hlt`, `instr_in`, `instr_jr`, `instr_jal`, `instr_ret`, `instr_jump`, `instr_branch` in 1 each, decoded instruction class, valid in EXECUTE
- `branch_taken` in 1, branch condition from ALU, valid in EXECUTE
- `jump_target` in ADDR_W, absolute target for jump/jal
- `reg_target` in ADDR_W, register-sourced target for jr
- `branch_offset` in ADDR_W, two's-complement offset for branch
- `in_valid` in 1, external input data available
- `resume` in 1, leave HALT
- `pc` out ADDR_W, current program counter
- `fetch_en` out 1, instruction-memory read strobe
- `ir_load` out 1, instruction-register load strobe
- `exec_en` out 1, one-cycle commit strobe (regfile/memory write enable)
- `in_ack` out 1, input consumed
- `halted` out 1, high while in HALT
- `ras_overflow`, `ras_underflow` out 1 each, sticky error flags
- `retired` out 16, count of committed instructions

## Operation
- States: FETCH → DECODE → EXECUTE → FETCH; plus WAIT_IN and HALT.
- FETCH: `fetch_en`=1. DECODE: `ir_load`=1. EXECUTE: decode inputs sampled, `exec_en`=1 unless stalling, PC updated on the exiting edge.
- EXECUTE priority (highest first): hlt, in, jr, jal, ret, jump, branch, sequential. Only the highest asserted class acts.
- hlt: `pc` unchanged, `exec_en`=0, go to HALT. In HALT `halted`=1. `resume`=1 → `pc`←`pc`+1, go to FETCH; the hlt retires at this point.
- in with `in_valid`=1: `in_ack`=1, `exec_en`=1, `pc`←`pc`+1. With `in_valid`=0: `exec_en`=0, go to WAIT_IN. In WAIT_IN the first cycle with `in_valid`=1 gives `in_ack`=1, `exec_en`=1, `pc`←`pc`+1, then FETCH.
- jr: `pc`←`reg_target`.
- jump: `pc`←`jump_target`.
- jal: push `pc`+1 onto the RAS, `pc`←`jump_target`. If the RAS is full, overwrite the oldest entry (circular) and set `ras_overflow`.
- ret: pop, `pc`←popped value. If the RAS is empty, `pc`←`pc`+1 and set `ras_underflow`.
- branch: taken → `pc`←`pc`+1+`branch_offset`; not taken → `pc`+1.
- All PC arithmetic is modulo 2^ADDR_W and wraps silently (max address +1 → 0).
- `retired` increments on every `exec_en` pulse and on the HALT→FETCH resume. It wraps at 2^16.
- Error flags clear only on reset.

## Timing
- Reset (any state, including mid-WAIT_IN or HALT): `pc`=RESET_PC, state FETCH, RAS empty, both flags 0, `retired`=0. All strobes, `in_ack` and `halted` are 0 in the reset cycle.
- Non-stalling instruction takes 3 cycles. New `pc` is visible in the cycle after EXECUTE, which is the next FETCH.
- Strobes are registered-state decodes, one cycle wide, mutually exclusive.
- `in_ack` is high only in the cycle that commits the input. `in_valid` arriving the same cycle as entering EXECUTE commits without WAIT_IN.
- `resume` is ignored outside HALT. `in_valid` is ignored outside EXECUTE/WAIT_IN.
- A push and a pop never occur in the same cycle. The RAS keeps its count and pointer across stalls.

## Test plan
- Reset, then 4 plain instructions → `pc` 0,1,2,3,4; `fetch_en`/`ir_load`/`exec_en` cycle in a 3-cycle pattern; `retired`=4.
- jump to 0x3F0; then sequential from 0x3FF → `pc`=0x3F0, later 0x3FF→0x000 wrap; branch at `pc`=5, offset 0x3FC (-4), taken → `pc`=2.
- jal at 10 → 0x100, jal at 0x100 → 0x200, ret, ret → `pc` 0x101 then 11. With RAS_DEPTH=4, 5 nested jals → `ras_overflow`=1; a ret on an empty RAS → `ras_underflow`=1 and `pc`+1.
- in with `in_valid` low for 5 cycles, then high → WAIT_IN held, `exec_en`=0, exactly one `in_ack` pulse, `pc`+1.
- hlt at `pc`=7 → `halted`=1 and `pc`=7 held for 20 cycles. `resume` → `pc`=8, FETCH, `retired` incremented once.
- Assert `reset` during WAIT_IN, during HALT, and with the RAS holding 3 entries → `pc`=RESET_PC, flags 0, a following ret underflows.
